// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 frame receiver
//
// Contents:
//   ps2_state_t            frame FSM state encoding (IDLE, DATA, PARITY, STOP)
//   PS2_DATA_BITS          data bits per frame
//   PS2_FRAME_BITS         total bits per frame (start + data + parity + stop)
//   DEFAULT_FILTER_LEN     default ps2_clk deglitch length in clk samples
//   DEFAULT_TIMEOUT_CYCLES default stalled-frame timeout in clk cycles
//   odd_parity_ok()        true when data plus parity bit has odd weight
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_DATA_BITS          = 8;
  localparam int PS2_FRAME_BITS         = 11;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - synchronise and deglitch ps2_clk, flag filtered falling edges
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ps2_clk  in   raw PS/2 clock pin (asynchronous)
//   fall     out  one-cycle strobe, filtered clock went 1 -> 0 on the last edge
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  output logic fall
);

  logic                  sync1;
  logic                  sync2;
  logic [FILTER_LEN-1:0] shifter;
  logic                  filt_clk;
  logic                  filt_clk_d;

  // Everything resets to the idle (high) line level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      shifter    <= '1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
    end else begin
      sync1      <= ps2_clk;
      sync2      <= sync1;
      shifter    <= {shifter[FILTER_LEN-2:0], sync2};
      // Level only changes on a unanimous window; mixed windows hold.
      if (shifter == '0) begin
        filt_clk <= 1'b0;
      end else if (&shifter) begin
        filt_clk <= 1'b1;
      end
      filt_clk_d <= filt_clk;
    end
  end

  assign fall = filt_clk_d & ~filt_clk;

endmodule

// File: rtl/ps2_frame_receiver.sv
// rtl/ps2_frame_receiver.sv - PS/2 keyboard frame deserialiser with error and timeout flags
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   ps2_clk     in   raw PS/2 clock pin
//   ps2_data    in   raw PS/2 data pin
//   dout        out  last good scan-code byte, held until the next good frame
//   dout_valid  out  one-cycle pulse when dout updates
//   parity_err  out  one-cycle pulse on parity mismatch
//   frame_err   out  one-cycle pulse on bad stop bit or stalled frame
//   busy        out  high while a frame is in progress
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     dout_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic                     fall;
  logic                     data_s1;
  logic                     data_s2;
  ps2_state_t               state;
  logic [2:0]               bit_cnt;
  logic [PS2_DATA_BITS-1:0] sr;
  logic                     par;
  logic [TW-1:0]            tcnt;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .ps2_clk(ps2_clk),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      sr         <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || state == ST_IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end

      // A fall in the timeout cycle is still a legitimate bit, so it takes priority.
      if (fall) begin
        unique case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            sr      <= {data_s2, sr[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par   <= data_s2;
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            // A bad stop bit masks any parity problem: the frame is not trustworthy.
            if (!data_s2) begin
              frame_err <= 1'b1;
            end else if (odd_parity_ok(sr, par)) begin
              dout       <= sr;
              dout_valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
